// File: rtl/tetris_pkg.sv
// Shared types for the Tetris datapath and its turn controller.
package tetris_pkg;

  // Player command carried on the move bus.
  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_ROTATE = 3'd3,
    CMD_DROP   = 3'd4
  } command_t;

  // Turn controller sequencing states.
  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_SPAWN = 3'd1,
    S_FALL  = 3'd2,
    S_LOCK  = 3'd3,
    S_CHECK = 3'd4,
    S_CLEAR = 3'd5,
    S_OVER  = 3'd6
  } game_ctrl_state_t;

  // Single enable issued during S_FALL in a given cycle.
  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_DROP   = 3'd1,
    ACT_LEFT   = 3'd2,
    ACT_RIGHT  = 3'd3,
    ACT_ROTATE = 3'd4
  } fall_act_t;

  localparam int unsigned LEVEL_STEP_DEFAULT = 10;

  // Map a player command to a fall action, dropping moves the collision checker blocks.
  function automatic fall_act_t resolve_move(command_t cmd, logic left_col,
                                             logic right_col, logic rot_col);
    fall_act_t act;
    act = ACT_NONE;
    case (cmd)
      CMD_LEFT:   act = left_col  ? ACT_NONE : ACT_LEFT;
      CMD_RIGHT:  act = right_col ? ACT_NONE : ACT_RIGHT;
      CMD_ROTATE: act = rot_col   ? ACT_NONE : ACT_ROTATE;
      default:    act = ACT_NONE;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/game_turn_controller_if.sv
// Datapath-facing bundle: one-cycle enables out, collision/board status in.
interface game_turn_controller_if;
  logic spawn_en;
  logic drop_en;
  logic shift_left_en;
  logic shift_right_en;
  logic rotate_en;
  logic lock_en;
  logic clear_en;
  logic board_wipe_en;
  logic left_collision;
  logic right_collision;
  logic down_collision;
  logic rotation_collision;
  logic spawn_blocked;
  logic any_full_row;

  modport master (
    output spawn_en, drop_en, shift_left_en, shift_right_en, rotate_en,
           lock_en, clear_en, board_wipe_en,
    input  left_collision, right_collision, down_collision, rotation_collision,
           spawn_blocked, any_full_row
  );

  modport slave (
    input  spawn_en, drop_en, shift_left_en, shift_right_en, rotate_en,
           lock_en, clear_en, board_wipe_en,
    output left_collision, right_collision, down_collision, rotation_collision,
           spawn_blocked, any_full_row
  );
endinterface

// File: rtl/game_turn_controller_tick.sv
// Brings a slow asynchronous strobe into clk and emits one pulse per rising edge.
module tick_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic tick_rise
);
  logic sync_a;
  logic sync_b;
  logic sync_d;

  // Two-flop synchroniser followed by a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync_a <= tick;
      sync_b <= sync_a;
      sync_d <= sync_b;
    end
  end

  assign tick_rise = sync_b & ~sync_d;
endmodule

// File: rtl/game_turn_controller.sv
// Turn sequencer for the Tetris datapath: spawn, gravity, moves, lock, line clear, score.
module game_turn_controller
  import tetris_pkg::*;
#(
  parameter int unsigned LINES_W    = 8,
  parameter int unsigned LEVEL_W    = 4,
  parameter int unsigned LEVEL_STEP = LEVEL_STEP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   game_tick,
  input  logic                   move_tick,
  input  logic                   move_valid,
  input  command_t               move,
  input  logic                   restart,
  game_turn_controller_if.master dp,
  output logic                   piece_active,
  output logic                   game_over,
  output logic [LINES_W-1:0]     lines_cleared,
  output logic [LEVEL_W-1:0]     level,
  output game_ctrl_state_t       ctrl_state
);

  localparam int unsigned LINE_CNT_W = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

  game_ctrl_state_t       state, state_n;
  fall_act_t              act, act_n;
  logic                   pend_valid, pend_valid_n;
  command_t               pend_cmd, pend_cmd_n;
  logic                   wipe, wipe_n;
  logic                   game_rise;
  logic                   move_rise;
  logic                   move_req;
  logic [LINE_CNT_W-1:0]  line_cnt;

  tick_edge_sync u_game_sync (
    .clk       (clk),
    .reset     (reset),
    .tick      (game_tick),
    .tick_rise (game_rise)
  );

  tick_edge_sync u_move_sync (
    .clk       (clk),
    .reset     (reset),
    .tick      (move_tick),
    .tick_rise (move_rise)
  );

  assign move_req = move_rise & move_valid;

  // State register plus the Moore-side action, pending move and wipe flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_WAIT;
      act        <= ACT_NONE;
      pend_valid <= 1'b0;
      pend_cmd   <= CMD_NONE;
      wipe       <= 1'b0;
    end else begin
      state      <= state_n;
      act        <= act_n;
      pend_valid <= pend_valid_n;
      pend_cmd   <= pend_cmd_n;
      wipe       <= wipe_n;
    end
  end

  // Next-state logic, including gravity-over-move arbitration in S_FALL.
  always_comb begin
    state_n      = state;
    act_n        = ACT_NONE;
    pend_valid_n = 1'b0;
    pend_cmd_n   = pend_cmd;
    wipe_n       = 1'b0;
    case (state)
      S_WAIT:  if (game_rise) state_n = S_SPAWN;
      S_SPAWN: state_n = dp.spawn_blocked ? S_OVER : S_FALL;
      S_FALL: begin
        pend_valid_n = pend_valid;
        // Gravity owns the next cycle; a coincident move is parked and
        // resolved against the collision flags only when it gets its turn.
        if (game_rise) begin
          if (dp.down_collision) begin
            state_n      = S_LOCK;
            pend_valid_n = 1'b0;
          end else begin
            act_n = ACT_DROP;
            if (move_req) begin
              pend_valid_n = 1'b1;
              pend_cmd_n   = move;
            end
          end
        end else if (move_req) begin
          act_n        = resolve_move(move, dp.left_collision, dp.right_collision,
                                      dp.rotation_collision);
          pend_valid_n = 1'b0;
        end else if (pend_valid) begin
          act_n        = resolve_move(pend_cmd, dp.left_collision, dp.right_collision,
                                      dp.rotation_collision);
          pend_valid_n = 1'b0;
        end
      end
      S_LOCK:  state_n = S_CHECK;
      S_CHECK: state_n = dp.any_full_row ? S_CLEAR : S_WAIT;
      S_CLEAR: state_n = S_CHECK;
      S_OVER: begin
        if (restart) begin
          state_n = S_WAIT;
          wipe_n  = 1'b1;
        end
      end
      default: state_n = S_WAIT;
    endcase
  end

  // Moore outputs decoded from state and the registered fall action.
  always_comb begin
    dp.spawn_en       = (state == S_SPAWN);
    dp.drop_en        = (state == S_FALL) && (act == ACT_DROP);
    dp.shift_left_en  = (state == S_FALL) && (act == ACT_LEFT);
    dp.shift_right_en = (state == S_FALL) && (act == ACT_RIGHT);
    dp.rotate_en      = (state == S_FALL) && (act == ACT_ROTATE);
    dp.lock_en        = (state == S_LOCK);
    dp.clear_en       = (state == S_CLEAR);
    dp.board_wipe_en  = wipe;
    piece_active      = (state == S_FALL);
    game_over         = (state == S_OVER);
  end

  assign ctrl_state = state;

  // Lines and level counters, advanced once per cleared row and zeroed on restart.
  always_ff @(posedge clk) begin
    if (reset || wipe_n) begin
      lines_cleared <= '0;
      level         <= '0;
      line_cnt      <= '0;
    end else if (state == S_CLEAR) begin
      if (lines_cleared != '1) lines_cleared <= lines_cleared + LINES_W'(1);
      if (line_cnt == LINE_CNT_W'(LEVEL_STEP - 1)) begin
        line_cnt <= '0;
        if (level != '1) level <= level + LEVEL_W'(1);
      end else begin
        line_cnt <= line_cnt + LINE_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed bench for game_turn_controller.
module tb_game_turn_controller;
  import tetris_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             game_tick;
  logic             move_tick;
  logic             move_valid;
  command_t         move;
  logic             restart;
  logic             piece_active;
  logic             game_over;
  logic [7:0]       lines_cleared;
  logic [3:0]       level;
  game_ctrl_state_t ctrl_state;

  game_turn_controller_if dp_if ();

  game_turn_controller #(
    .LINES_W    (8),
    .LEVEL_W    (4),
    .LEVEL_STEP (10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .game_tick     (game_tick),
    .move_tick     (move_tick),
    .move_valid    (move_valid),
    .move          (move),
    .restart       (restart),
    .dp            (dp_if),
    .piece_active  (piece_active),
    .game_over     (game_over),
    .lines_cleared (lines_cleared),
    .level         (level),
    .ctrl_state    (ctrl_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int multi_hits = 0;
  int n_en;
  int c_spawn, c_drop, c_left, c_right, c_rot, c_lock, c_clear, c_wipe;
  int t_spawn, t_drop, t_left, t_lock, t_clear_first, t_clear_last;

  task automatic clr_counts();
    c_spawn = 0; c_drop = 0; c_left = 0; c_right = 0; c_rot = 0;
    c_lock = 0; c_clear = 0; c_wipe = 0;
    t_spawn = -1; t_drop = -1; t_left = -1; t_lock = -1;
    t_clear_first = -1; t_clear_last = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    n_en = int'(dp_if.spawn_en) + int'(dp_if.drop_en) + int'(dp_if.shift_left_en) +
           int'(dp_if.shift_right_en) + int'(dp_if.rotate_en) + int'(dp_if.lock_en) +
           int'(dp_if.clear_en) + int'(dp_if.board_wipe_en);
    if (n_en > 1) multi_hits++;
    if (dp_if.spawn_en)       begin c_spawn++; t_spawn = cyc; end
    if (dp_if.drop_en)        begin c_drop++;  t_drop  = cyc; end
    if (dp_if.shift_left_en)  begin c_left++;  t_left  = cyc; end
    if (dp_if.shift_right_en) c_right++;
    if (dp_if.rotate_en)      c_rot++;
    if (dp_if.lock_en)        begin c_lock++;  t_lock  = cyc; end
    if (dp_if.clear_en) begin
      c_clear++;
      if (t_clear_first < 0) t_clear_first = cyc;
      t_clear_last = cyc;
    end
    if (dp_if.board_wipe_en)  c_wipe++;
  endtask

  task automatic game_pulse();
    game_tick = 1'b1;
    repeat (4) step();
    game_tick = 1'b0;
    repeat (4) step();
  endtask

  task automatic move_pulse(input command_t cmd, input logic valid);
    move = cmd;
    move_valid = valid;
    move_tick = 1'b1;
    repeat (4) step();
    move_tick = 1'b0;
    move_valid = 1'b0;
    repeat (4) step();
  endtask

  // Spawn a piece, lock it at once and let n full rows clear.
  task automatic play_piece(input int n);
    int base;
    dp_if.spawn_blocked = 1'b0;
    dp_if.down_collision = 1'b0;
    dp_if.any_full_row = 1'b0;
    game_pulse();
    base = c_clear;
    dp_if.down_collision = 1'b1;
    dp_if.any_full_row = (n > 0);
    game_tick = 1'b1;
    repeat (2 * n + 10) begin
      step();
      if (c_clear - base >= n) dp_if.any_full_row = 1'b0;
    end
    game_tick = 1'b0;
    dp_if.down_collision = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    checks++;
    if (ctrl_state !== S_WAIT) begin errors++; $display("FAIL reset_state: got %0d expected %0d", ctrl_state, S_WAIT); end
    checks++;
    if (n_en !== 0) begin errors++; $display("FAIL reset_enables: got %0d expected 0", n_en); end
    checks++;
    if (piece_active !== 1'b0) begin errors++; $display("FAIL reset_piece_active: got %b expected 0", piece_active); end
    checks++;
    if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
    checks++;
    if (lines_cleared !== 8'd0) begin errors++; $display("FAIL reset_lines: got %0d expected 0", lines_cleared); end
    checks++;
    if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
  endtask

  task automatic test_spawn();
    int t0;
    clr_counts();
    dp_if.spawn_blocked = 1'b0;
    dp_if.down_collision = 1'b0;
    t0 = cyc;
    game_tick = 1'b1;
    repeat (6) step();
    game_tick = 1'b0;
    repeat (2) step();
    checks++;
    if (c_spawn !== 1) begin errors++; $display("FAIL spawn_count: got %0d expected 1", c_spawn); end
    checks++;
    if (t_spawn !== t0 + 3) begin errors++; $display("FAIL spawn_latency: got %0d expected %0d", t_spawn - t0, 3); end
    checks++;
    if (ctrl_state !== S_FALL) begin errors++; $display("FAIL spawn_next_state: got %0d expected %0d", ctrl_state, S_FALL); end
    checks++;
    if (piece_active !== 1'b1) begin errors++; $display("FAIL spawn_piece_active: got %b expected 1", piece_active); end
    checks++;
    if (c_drop !== 0) begin errors++; $display("FAIL held_tick_no_repeat: got %0d drops expected 0", c_drop); end
  endtask

  task automatic test_drop();
    int others;
    clr_counts();
    dp_if.down_collision = 1'b0;
    repeat (3) game_pulse();
    others = c_spawn + c_left + c_right + c_rot + c_lock + c_clear + c_wipe;
    checks++;
    if (c_drop !== 3) begin errors++; $display("FAIL drop_count: got %0d expected 3", c_drop); end
    checks++;
    if (others !== 0) begin errors++; $display("FAIL drop_other_enables: got %0d expected 0", others); end
    checks++;
    if (ctrl_state !== S_FALL) begin errors++; $display("FAIL drop_state: got %0d expected %0d", ctrl_state, S_FALL); end
  endtask

  task automatic test_moves();
    clr_counts();
    dp_if.left_collision = 1'b1;
    move_pulse(CMD_LEFT, 1'b1);
    checks++;
    if (c_left !== 0) begin errors++; $display("FAIL left_blocked: got %0d expected 0", c_left); end
    dp_if.left_collision = 1'b0;
    move_pulse(CMD_LEFT, 1'b1);
    checks++;
    if (c_left !== 1) begin errors++; $display("FAIL left_free: got %0d expected 1", c_left); end
    move_pulse(CMD_RIGHT, 1'b0);
    checks++;
    if (c_right !== 0) begin errors++; $display("FAIL move_not_valid: got %0d expected 0", c_right); end
    dp_if.right_collision = 1'b1;
    move_pulse(CMD_RIGHT, 1'b1);
    checks++;
    if (c_right !== 0) begin errors++; $display("FAIL right_blocked: got %0d expected 0", c_right); end
    dp_if.right_collision = 1'b0;
    move_pulse(CMD_RIGHT, 1'b1);
    checks++;
    if (c_right !== 1) begin errors++; $display("FAIL right_free: got %0d expected 1", c_right); end
    dp_if.rotation_collision = 1'b0;
    move_pulse(CMD_ROTATE, 1'b1);
    checks++;
    if (c_rot !== 1) begin errors++; $display("FAIL rotate_free: got %0d expected 1", c_rot); end
    checks++;
    if (c_drop !== 0) begin errors++; $display("FAIL moves_no_drop: got %0d expected 0", c_drop); end
  endtask

  task automatic test_back_to_back();
    int t0;
    clr_counts();
    dp_if.left_collision = 1'b0;
    t0 = cyc;
    game_tick = 1'b1;
    move_tick = 1'b1;
    move = CMD_LEFT;
    move_valid = 1'b1;
    repeat (4) step();
    game_tick = 1'b0;
    move_tick = 1'b0;
    move_valid = 1'b0;
    repeat (4) step();
    checks++;
    if (c_drop !== 1 || c_left !== 1) begin errors++; $display("FAIL coincide_counts: got drop %0d left %0d expected 1 1", c_drop, c_left); end
    checks++;
    if (t_drop !== t0 + 3) begin errors++; $display("FAIL coincide_drop_cycle: got %0d expected %0d", t_drop - t0, 3); end
    checks++;
    if (t_left !== t_drop + 1) begin errors++; $display("FAIL coincide_left_cycle: got %0d expected %0d", t_left - t0, 4); end
  endtask

  task automatic test_lock_clear();
    int t0;
    clr_counts();
    dp_if.down_collision = 1'b1;
    dp_if.any_full_row = 1'b1;
    t0 = cyc;
    game_tick = 1'b1;
    repeat (12) begin
      step();
      if (c_clear >= 2) dp_if.any_full_row = 1'b0;
    end
    game_tick = 1'b0;
    dp_if.down_collision = 1'b0;
    step();
    checks++;
    if (c_lock !== 1 || t_lock !== t0 + 3) begin errors++; $display("FAIL lock_pulse: got count %0d at %0d expected 1 at 3", c_lock, t_lock - t0); end
    checks++;
    if (c_clear !== 2) begin errors++; $display("FAIL clear_count: got %0d expected 2", c_clear); end
    checks++;
    if (t_clear_first !== t0 + 5 || t_clear_last !== t0 + 7) begin errors++; $display("FAIL clear_spacing: got %0d,%0d expected 5,7", t_clear_first - t0, t_clear_last - t0); end
    checks++;
    if (lines_cleared !== 8'd2) begin errors++; $display("FAIL lines_after_clear: got %0d expected 2", lines_cleared); end
    checks++;
    if (ctrl_state !== S_WAIT) begin errors++; $display("FAIL clear_return_state: got %0d expected %0d", ctrl_state, S_WAIT); end
  endtask

  task automatic test_level();
    play_piece(7);
    checks++;
    if (lines_cleared !== 8'd9 || level !== 4'd0) begin errors++; $display("FAIL level_at_9: got lines %0d level %0d expected 9 0", lines_cleared, level); end
    play_piece(1);
    checks++;
    if (lines_cleared !== 8'd10 || level !== 4'd1) begin errors++; $display("FAIL level_at_10: got lines %0d level %0d expected 10 1", lines_cleared, level); end
  endtask

  task automatic test_saturation();
    play_piece(245);
    checks++;
    if (lines_cleared !== 8'd255) begin errors++; $display("FAIL lines_reach_max: got %0d expected 255", lines_cleared); end
    checks++;
    if (level !== 4'd15) begin errors++; $display("FAIL level_saturate: got %0d expected 15", level); end
    play_piece(1);
    checks++;
    if (lines_cleared !== 8'd255 || level !== 4'd15) begin errors++; $display("FAIL lines_saturate: got lines %0d level %0d expected 255 15", lines_cleared, level); end
  endtask

  task automatic test_game_over();
    clr_counts();
    dp_if.spawn_blocked = 1'b1;
    game_pulse();
    checks++;
    if (game_over !== 1'b1 || ctrl_state !== S_OVER) begin errors++; $display("FAIL over_entry: got game_over %b state %0d expected 1 %0d", game_over, ctrl_state, S_OVER); end
    checks++;
    if (piece_active !== 1'b0 || c_spawn !== 1) begin errors++; $display("FAIL over_spawn_once: got piece_active %b spawns %0d expected 0 1", piece_active, c_spawn); end
    dp_if.spawn_blocked = 1'b0;
    game_pulse();
    move_pulse(CMD_LEFT, 1'b1);
    checks++;
    if (c_spawn !== 1 || c_left !== 0 || c_drop !== 0 || ctrl_state !== S_OVER) begin errors++; $display("FAIL over_ignores_input: got spawns %0d left %0d drop %0d state %0d expected 1 0 0 %0d", c_spawn, c_left, c_drop, ctrl_state, S_OVER); end
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (dp_if.board_wipe_en !== 1'b1) begin errors++; $display("FAIL wipe_pulse: got %b expected 1", dp_if.board_wipe_en); end
    step();
    checks++;
    if (dp_if.board_wipe_en !== 1'b0 || c_wipe !== 1) begin errors++; $display("FAIL wipe_one_cycle: got en %b count %0d expected 0 1", dp_if.board_wipe_en, c_wipe); end
    checks++;
    if (lines_cleared !== 8'd0 || level !== 4'd0) begin errors++; $display("FAIL restart_counters: got lines %0d level %0d expected 0 0", lines_cleared, level); end
    checks++;
    if (ctrl_state !== S_WAIT || game_over !== 1'b0) begin errors++; $display("FAIL restart_state: got state %0d game_over %b expected %0d 0", ctrl_state, game_over, S_WAIT); end
  endtask

  task automatic test_reset_mid_clear();
    int k;
    dp_if.spawn_blocked = 1'b0;
    dp_if.down_collision = 1'b0;
    game_pulse();
    dp_if.down_collision = 1'b1;
    dp_if.any_full_row = 1'b1;
    game_tick = 1'b1;
    k = 0;
    while (ctrl_state != S_CLEAR && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (ctrl_state !== S_CLEAR) begin errors++; $display("FAIL reach_clear: got state %0d expected %0d", ctrl_state, S_CLEAR); end
    reset = 1'b1;
    step();
    checks++;
    if (ctrl_state !== S_WAIT || n_en !== 0) begin errors++; $display("FAIL mid_reset_state: got state %0d enables %0d expected %0d 0", ctrl_state, n_en, S_WAIT); end
    checks++;
    if (lines_cleared !== 8'd0 || level !== 4'd0 || game_over !== 1'b0 || piece_active !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got lines %0d level %0d over %b active %b expected 0 0 0 0", lines_cleared, level, game_over, piece_active); end
    repeat (2) begin
      step();
      checks++;
      if (n_en !== 0) begin errors++; $display("FAIL enable_during_reset: got %0d expected 0", n_en); end
    end
    reset = 1'b0;
    game_tick = 1'b0;
    dp_if.any_full_row = 1'b0;
    dp_if.down_collision = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_one_hot();
    checks++;
    if (multi_hits !== 0) begin errors++; $display("FAIL enable_one_hot: got %0d multi-enable cycles expected 0", multi_hits); end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    game_tick = 1'b0;
    move_tick = 1'b0;
    move_valid = 1'b0;
    move = CMD_NONE;
    restart = 1'b0;
    dp_if.left_collision = 1'b0;
    dp_if.right_collision = 1'b0;
    dp_if.down_collision = 1'b0;
    dp_if.rotation_collision = 1'b0;
    dp_if.spawn_blocked = 1'b0;
    dp_if.any_full_row = 1'b0;
    clr_counts();
    repeat (3) step();
    reset = 1'b0;
    step();
    test_reset();
    test_spawn();
    test_drop();
    test_moves();
    test_back_to_back();
    test_lock_clear();
    test_level();
    test_saturation();
    test_game_over();
    test_reset_mid_clear();
    test_one_hot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_turn_controller.md
Name: game_turn_controller

Overview:
- Central sequencer for the Tetris game datapath: piece position/rotation flops, fixed-board flop, line-clear shifter, collision checker.
- Turns the slow game_tick and move_tick strobes into single-cycle enables in the clk domain: spawn, drop, shift, rotate, lock, clear, board wipe.
- Arbitrates player moves against gravity, so the datapath never sees two state-changing enables in the same cycle.
- Also tracks lines cleared, level and game-over.

Parameters:
- LINES_W, 8, width of lines_cleared counter (saturates at all-ones).
- LEVEL_W, 4, width of level output (saturates at all-ones).
- LEVEL_STEP, 10, lines per level increment.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- game_tick  in  1  slow gravity "clock", asynchronous to clk.
- move_tick  in  1  slow move strobe, asynchronous to clk.
- move_valid  in  1  move field valid, sampled at move rise.
- move  in  tetris_pkg::command_t  player command.
- restart  in  1  level-sensitive restart request; honoured only in S_OVER.
- left_collision, right_collision, down_collision, rotation_collision  in  1 each  collision-checker flags for the current piece.
- spawn_blocked  in  1  the newly loaded piece overlaps the fixed board.
- any_full_row  in  1  the fixed board has at least one full row.
- spawn_en, drop_en, shift_left_en, shift_right_en, rotate_en, lock_en, clear_en, board_wipe_en  out  1 each  one-cycle datapath enables.
- piece_active  out  1  a piece is on the board (S_FALL).
- game_over  out  1  held high in S_OVER.
- lines_cleared  out  LINES_W  total lines cleared.
- level  out  LEVEL_W  current level.
- ctrl_state  out  game_ctrl_state_t  FSM state, for debug windows.

Behaviour:
- Reset values:
  - state = S_WAIT; all enables 0; piece_active = 0; game_over = 0; lines_cleared = 0; level = 0.
  - Internal line counter 0; pending move cleared; tick synchronisers cleared.
  - Reset mid-operation aborts any state in the next cycle; no enable fires during reset.
- Tick detection:
  - game_tick and move_tick each pass through a 2-flop synchroniser plus a delayed copy.
  - tick_rise = sync & ~sync_d, a one-cycle pulse 2 clk cycles after the input is first sampled high.
  - One pulse per input rising edge; a held-high input gives no repeat.
- Enables are Moore outputs of the current state; at most one enable is high in any cycle.
- States:
  - S_WAIT: game_tick rise -> S_SPAWN.
  - S_SPAWN (1 cycle): spawn_en = 1. Next cycle: spawn_blocked -> S_OVER, else -> S_FALL.
  - S_FALL: piece_active = 1.
    - game_tick rise with down_collision -> S_LOCK.
    - game_tick rise without down_collision -> drop_en for 1 cycle, stay in S_FALL.
    - move rise with move_valid -> one move enable the following cycle:
      - CMD_LEFT & ~left_collision -> shift_left_en.
      - CMD_RIGHT & ~right_collision -> shift_right_en.
      - CMD_ROTATE & ~rotation_collision -> rotate_en.
      - Blocked or other commands -> nothing.
    - Gravity/move arbitration: if the game and move rises coincide, gravity wins and the move is latched in pending (depth 1).
    - A pending move executes on the first cycle after the drop in which no other enable is issued. Collision flags are re-evaluated at execute time.
    - A pending move is discarded on leaving S_FALL.
    - A new move rise while one is pending overwrites it.
  - S_LOCK (1 cycle): lock_en = 1 -> S_CHECK.
  - S_CHECK (1 cycle; the board flop settles here): any_full_row -> S_CLEAR, else -> S_WAIT.
  - S_CLEAR (1 cycle): clear_en = 1 -> S_CHECK. Multiple full rows therefore clear at one per 2 cycles.
  - S_OVER: game_over = 1; moves and ticks ignored. restart -> board_wipe_en for 1 cycle, counters zeroed, -> S_WAIT.
- Counters:
  - Each clear_en increments lines_cleared, saturating at 2^LINES_W-1.
  - The internal line counter counts 0..LEVEL_STEP-1. At wrap, level increments (saturating) and the counter returns to 0.
- The spawn_en/spawn_blocked check occurs exactly once per piece.

Decomposition:
- In the shared tetris_pkg: the game_ctrl_state_t enum (S_WAIT, S_SPAWN, S_FALL, S_LOCK, S_CHECK, S_CLEAR, S_OVER) and the LEVEL_STEP default constant. command_t is reused unchanged.
- One sub-module: tick_edge_sync (2-flop sync + rise pulse, reset clears). Instantiated twice.
- FSM, arbitration and counters stay in game_turn_controller.

Test Plan:
- Reset, then one game_tick rise -> spawn_en exactly 1 cycle, 3 cycles after the rise is sampled; next state S_FALL; piece_active = 1.
- In S_FALL with down_collision = 0, 3 game_tick rises -> exactly 3 drop_en pulses, no other enables.
- move = CMD_LEFT with left_collision = 1 -> no shift_left_en. With left_collision = 0 -> 1 shift_left_en. Coincident game/move rises -> drop_en in cycle N, shift_left_en in N+1.
- down_collision = 1 at tick, any_full_row high for 2 checks -> lock_en, then 2 clear_en pulses 2 cycles apart; lines_cleared 0 -> 2; state returns to S_WAIT.
- Start from lines_cleared = 9, then 1 clear with LEVEL_STEP = 10 -> level 0 -> 1. Pre-load lines_cleared = 255 -> stays 255.
- spawn_blocked = 1 after spawn -> game_over = 1, ticks ignored; restart -> board_wipe_en 1 cycle, counters 0. Reset asserted mid-S_CLEAR -> next cycle S_WAIT, all outputs 0.
